// File: rtl/acq_sequencer_if.sv
// Bundle between the acquisition sequencer and its neighbours: host controls,
// DiscReader byte stream, acquisition RAM write port and capture status.
interface acq_sequencer_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int IDX_WIDTH  = 8
);
  logic                  start;
  logic                  abort;
  logic                  start_on_index;
  logic [IDX_WIDTH-1:0]  stop_index_count;
  logic                  index;
  logic                  rd_valid;
  logic [7:0]            rd_data;

  logic                  reader_enable;
  logic                  waiting;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  stat_full;
  logic                  stat_abort;
  logic [ADDR_WIDTH:0]   byte_count;

  modport master (
    output start, abort, start_on_index, stop_index_count, index, rd_valid, rd_data,
    input  reader_enable, waiting, busy, done, mem_we, mem_addr, mem_wdata,
           stat_full, stat_abort, byte_count
  );

  modport slave (
    input  start, abort, start_on_index, stop_index_count, index, rd_valid, rd_data,
    output reader_enable, waiting, busy, done, mem_we, mem_addr, mem_wdata,
           stat_full, stat_abort, byte_count
  );
endinterface

// File: rtl/acq_sequencer.sv
// Disc capture sequencer: arms on start (optionally waiting for index), stores
// reader bytes into acquisition RAM, stops on index count, memory full or abort.
module acq_sequencer #(
  parameter int ADDR_WIDTH = 19,
  parameter int IDX_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  acq_sequencer_if.slave   seq_io
);

  typedef enum logic [1:0] {IDLE, WAIT_IDX, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state_q, state_d;
  logic                  idx_prev_q;
  logic                  idx_edge;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
  logic [IDX_WIDTH-1:0]  idx_cnt_q, idx_cnt_d;
  logic [IDX_WIDTH-1:0]  stop_cnt_q, stop_cnt_d;
  logic                  stat_full_q, stat_full_d;
  logic                  stat_abort_q, stat_abort_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  reader_enable_q, waiting_q, busy_q, done_q;

  assign idx_edge = seq_io.index & ~idx_prev_q;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    byte_count_d = byte_count_q;
    idx_cnt_d    = idx_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    stat_full_d  = stat_full_q;
    stat_abort_d = stat_abort_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (seq_io.start) begin
          wptr_d       = '0;
          byte_count_d = '0;
          idx_cnt_d    = '0;
          stat_full_d  = 1'b0;
          stat_abort_d = 1'b0;
          stop_cnt_d   = seq_io.stop_index_count;
          state_d      = seq_io.start_on_index ? WAIT_IDX : RUN;
        end
      end

      WAIT_IDX: begin
        if (seq_io.abort) begin
          stat_abort_d = 1'b1;
          state_d      = IDLE;
        end else if (idx_edge) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (seq_io.abort) begin
          // A byte arriving alongside abort is dropped on purpose.
          stat_abort_d = 1'b1;
          state_d      = IDLE;
        end else begin
          if (idx_edge) begin
            idx_cnt_d = idx_cnt_q + 1'b1;
            if ((stop_cnt_q != '0) && (idx_cnt_d == stop_cnt_q)) begin
              state_d = IDLE;
            end
          end
          if (seq_io.rd_valid) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = wptr_q;
            mem_wdata_d  = seq_io.rd_data;
            byte_count_d = byte_count_q + 1'b1;
            if (wptr_q == LAST_ADDR) begin
              // Pointer parks at the top; the next start rewinds it.
              stat_full_d = 1'b1;
              state_d     = IDLE;
            end else begin
              wptr_d = wptr_q + 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_prev_q      <= 1'b1;
      wptr_q          <= '0;
      byte_count_q    <= '0;
      idx_cnt_q       <= '0;
      stop_cnt_q      <= '0;
      stat_full_q     <= 1'b0;
      stat_abort_q    <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      reader_enable_q <= 1'b0;
      waiting_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_prev_q      <= seq_io.index;
      wptr_q          <= wptr_d;
      byte_count_q    <= byte_count_d;
      idx_cnt_q       <= idx_cnt_d;
      stop_cnt_q      <= stop_cnt_d;
      stat_full_q     <= stat_full_d;
      stat_abort_q    <= stat_abort_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      reader_enable_q <= (state_d == RUN);
      waiting_q       <= (state_d == WAIT_IDX);
      busy_q          <= (state_d != IDLE);
      done_q          <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  assign seq_io.reader_enable = reader_enable_q;
  assign seq_io.waiting       = waiting_q;
  assign seq_io.busy          = busy_q;
  assign seq_io.done          = done_q;
  assign seq_io.mem_we        = mem_we_q;
  assign seq_io.mem_addr      = mem_addr_q;
  assign seq_io.mem_wdata     = mem_wdata_q;
  assign seq_io.stat_full     = stat_full_q;
  assign seq_io.stat_abort    = stat_abort_q;
  assign seq_io.byte_count    = byte_count_q;

endmodule
